imm_gen: RTL and testbench

IMM_GEN -- requirements
Module: imm_gen

---
 rtl/imm_gen_pkg.sv | 26 ++
 rtl/imm_decode.sv | 39 +++
 rtl/imm_gen.sv | 48 ++++
 tb/tb_imm_gen.sv | 120 ++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the RV32 12-bit immediate extractor: opcodes,
// immediate format encoding and the zero-extension helper.
package imm_gen_pkg;

  localparam int DATA_W  = 32;
  localparam int FIELD_W = 12;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_SB   = 2'd3
  } imm_type_e;

  // The immediate is delivered unsigned: upper bits are always zero.
  function automatic logic [DATA_W-1:0] zext_field(input logic [FIELD_W-1:0] field);
    return {{(DATA_W - FIELD_W){1'b0}}, field};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode decode and 12-bit immediate field extraction.
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [DATA_W-1:0]  instr,
  output logic [FIELD_W-1:0] field,
  output imm_type_e          fmt
);

  // funct3 and rs1 never influence the format or the field.
  logic unused_bits;
  assign unused_bits = ^instr[19:12];

  // Select the format from the opcode alone, then gather that format's bits.
  always_comb begin
    field = '0;
    fmt   = IMM_NONE;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt   = IMM_I;
        field = instr[31:20];
      end
      OP_STORE: begin
        fmt   = IMM_S;
        field = {instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        // Branch offset kept unshifted: bit 0 of the field is instr[8].
        fmt   = IMM_SB;
        field = {instr[31], instr[7], instr[30:25], instr[11:8]};
      end
      default: begin
        fmt   = IMM_NONE;
        field = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// Registered RV32 immediate generator: one-cycle decode of a 12-bit
// immediate, zero-extended to 32 bits, with a valid flag and format tag.
module imm_gen
  import imm_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic [1:0]        imm_type
);

  logic [FIELD_W-1:0] field_p0;
  imm_type_e          fmt_p0;

  logic [DATA_W-1:0]  imm_p1;
  imm_type_e          fmt_p1;
  logic               vld_p1;

  imm_decode u_decode (
    .instr (instr),
    .field (field_p0),
    .fmt   (fmt_p0)
  );

  // p0 -> p1: valid follows every cycle; data and format load only on valid
  // so an idle cycle leaves the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      imm_p1 <= '0;
      fmt_p1 <= IMM_NONE;
    end else begin
      vld_p1 <= instr_valid;
      if (instr_valid) begin
        imm_p1 <= zext_field(field_p0);
        fmt_p1 <= fmt_p0;
      end
    end
  end

  assign out       = imm_p1;
  assign out_valid = vld_p1;
  assign imm_type  = fmt_p1;

endmodule

// File: tb/tb_imm_gen.sv
// Directed self-checking bench for imm_gen.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] out;
  logic        out_valid;
  logic [1:0]  imm_type;

  int n_cmp = 0;
  int n_err = 0;

  localparam int NV = 9;
  logic [31:0] vec_instr [NV] = '{32'h00700013, 32'hE0700013, 32'hE0700023,
                                  32'h007001A3, 32'h00000163, 32'h02000063,
                                  32'h000000E3, 32'h80000063, 32'h02000033};
  logic [31:0] vec_out   [NV] = '{32'd7, 32'd3591, 32'd3584, 32'd3, 32'd1,
                                  32'd16, 32'd1024, 32'd2048, 32'd0};
  logic [1:0]  vec_type  [NV] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                                  2'd3, 2'd3, 2'd0};

  imm_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .out         (out),
    .out_valid   (out_valid),
    .imm_type    (imm_type)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input int i);
    chk({tag, "_out"},   out,              vec_out[i]);
    chk({tag, "_type"},  {30'd0, imm_type}, {30'd0, vec_type[i]});
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr       = 32'hFFFF_FFFF;
    instr_valid = 1'b1;
    #3;
    chk("rst_out",   out,                32'd0);
    chk("rst_type",  {30'd0, imm_type},  32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // Individual vectors with an idle cycle between each.
    for (int i = 0; i < NV; i++) begin
      instr       = vec_instr[i];
      instr_valid = 1'b1;
      @(negedge clk);
      chk_vec($sformatf("single%0d", i), i);
      instr_valid = 1'b0;
      @(negedge clk);
    end

    // Back-to-back stream, valid held high.
    instr       = vec_instr[0];
    instr_valid = 1'b1;
    for (int i = 1; i <= NV; i++) begin
      @(negedge clk);
      chk_vec($sformatf("b2b%0d", i - 1), i - 1);
      if (i < NV) instr = vec_instr[i];
    end

    // One idle cycle: valid drops once, data held, then resumes.
    instr_valid = 1'b0;
    instr       = vec_instr[0];
    @(negedge clk);
    chk("gap_valid", {31'd0, out_valid}, 32'd0);
    chk("gap_out",   out,                vec_out[NV-1]);
    chk("gap_type",  {30'd0, imm_type},  {30'd0, vec_type[NV-1]});
    instr_valid = 1'b1;
    instr       = vec_instr[1];
    @(negedge clk);
    chk_vec("resume", 1);

    // Mid-stream asynchronous reset between clock edges.
    instr = vec_instr[2];
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out",   out,                32'd0);
    chk("async_type",  {30'd0, imm_type},  32'd0);
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("inrst_valid", {31'd0, out_valid}, 32'd0);
    instr = vec_instr[5];
    rst_n = 1'b1;
    @(negedge clk);
    chk_vec("post_rst", 5);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("final_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
